// File: rtl/mult_sequencer_if.sv
// Command, result and shared-ALU signals of the shift-add multiplier.
// The slave modport is the sequencer; the master modport is its client plus the ALU.
interface mult_sequencer_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic         abort;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         busy;
  logic         done;
  logic [N-1:0] product_hi;
  logic [N-1:0] product_lo;
  logic [N-1:0] alu_InA;
  logic [N-1:0] alu_InB;
  logic [3:0]   alu_Op;
  logic         alu_Cin;
  logic         alu_invA;
  logic         alu_invB;
  logic         alu_sign;
  logic [N-1:0] alu_Out;
  logic         alu_Ofl;

  modport slave (
    input  start, abort, mcand, mplier, alu_Out, alu_Ofl,
    output busy, done, product_hi, product_lo,
    output alu_InA, alu_InB, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign
  );

  modport master (
    output start, abort, mcand, mplier, alu_Out, alu_Ofl,
    input  busy, done, product_hi, product_lo,
    input  alu_InA, alu_InB, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign
  );
endinterface

// File: rtl/mult_sequencer.sv
// Unsigned N x N shift-add multiplier that borrows an external adder for its partial sums.
// One iteration per cycle; N iterations in RUN, then a single-cycle DONE pulse.
module mult_sequencer #(
  parameter int unsigned N = 16
) (
  input logic             clk,
  input logic             rst_n,
  mult_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT         stateQ, stateD;
  logic [N-1:0]  pHiQ, pHiD;
  logic [N-1:0]  pLoQ, pLoD;
  logic [N-1:0]  mcQ, mcD;
  logic [CntW-1:0] cntQ, cntD;

  // Partial sum: add the multiplicand only when the current multiplier bit is set.
  logic          carry;
  logic [N-1:0]  sum;

  always_comb begin
    if (pLoQ[0]) begin
      carry = bus.alu_Ofl;
      sum   = bus.alu_Out;
    end else begin
      carry = 1'b0;
      sum   = pHiQ;
    end
  end

  always_comb begin
    stateD = stateQ;
    pHiD   = pHiQ;
    pLoD   = pLoQ;
    mcD    = mcQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          mcD    = bus.mcand;
          pLoD   = bus.mplier;
          pHiD   = '0;
          cntD   = '0;
          stateD = StRun;
        end
      end
      StRun: begin
        // Abort wins even on the last iteration.
        if (bus.abort) begin
          pHiD   = '0;
          pLoD   = '0;
          cntD   = '0;
          stateD = StIdle;
        end else begin
          {pHiD, pLoD} = {carry, sum, pLoQ[N-1:1]};
          cntD         = cntQ + CntW'(1);
          if (cntQ == CntW'(N - 1)) begin
            stateD = StDone;
          end
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      pHiQ   <= '0;
      pLoQ   <= '0;
      mcQ    <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      pHiQ   <= pHiD;
      pLoQ   <= pLoD;
      mcQ    <= mcD;
      cntQ   <= cntD;
    end
  end

  assign bus.busy       = (stateQ == StRun);
  assign bus.done       = (stateQ == StDone);
  assign bus.product_hi = pHiQ;
  assign bus.product_lo = pLoQ;

  assign bus.alu_InA  = pHiQ;
  assign bus.alu_InB  = mcQ;
  assign bus.alu_Op   = 4'd0;
  assign bus.alu_Cin  = 1'b0;
  assign bus.alu_invA = 1'b0;
  assign bus.alu_invB = 1'b0;
  assign bus.alu_sign = 1'b0;
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: vector table, scoreboard on done, and
// hand sequences for abort, reset and back-to-back operation.
module tb_mult_sequencer;
  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_sequencer_if #(.N(N)) bus();

  mult_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural model of the shared ALU in ADD mode.
  assign {bus.alu_Ofl, bus.alu_Out} = {1'b0, bus.alu_InA} + {1'b0, bus.alu_InB};

  int nChecks = 0;
  int nFail = 0;
  logic [31:0] expQ[$];

  typedef struct {
    logic [15:0] mc;
    logic [15:0] mp;
    logic [31:0] prod;
  } vecT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL unexpected_done: got product 0x%0h, want no done",
                 {bus.product_hi, bus.product_lo});
      end else begin
        check("product", {bus.product_hi, bus.product_lo}, expQ.pop_front());
      end
    end
  end

  task automatic runOp(input logic [15:0] mc, input logic [15:0] mp, input logic [31:0] exp,
                       input bit noSync);
    int lat;
    int busyCnt;
    if (!noSync) @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = mc;
    bus.mplier = mp;
    expQ.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    check("alu_InB_captured", 32'(bus.alu_InB), 32'(mc));
    check("alu_InA_cleared", 32'(bus.alu_InA), 32'd0);
    lat = 1;
    busyCnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busyCnt++;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd17);
    check("busy_cycles", 32'(busyCnt), 32'd16);
    @(negedge clk);
    check("done_one_cycle", {30'd0, bus.busy, bus.done}, 32'd0);
    check("product_hold", {bus.product_hi, bus.product_lo}, exp);
  endtask

  vecT vecs[7];
  int doneAt[$];

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[3] = '{16'h1234, 16'h5678, 32'h0626_0060};
    vecs[4] = '{16'h0000, 16'hABCD, 32'h0000_0000};
    vecs[5] = '{16'hABCD, 16'h0001, 32'h0000_ABCD};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};

    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    rst_n      = 1'b0;
    #12;
    check("reset_status", {30'd0, bus.busy, bus.done}, 32'd0);
    check("reset_product", {bus.product_hi, bus.product_lo}, 32'd0);
    check("reset_alu_ops", {bus.alu_InA, bus.alu_InB}, 32'd0);
    check("alu_ctrl", {27'd0, bus.alu_Op, bus.alu_Cin, bus.alu_invA, bus.alu_invB,
                       bus.alu_sign} , 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      runOp(vecs[i].mc, vecs[i].mp, vecs[i].prod, 1'b0);
    end

    // Abort at iteration 8: back to idle, cleared products, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'd3; bus.mplier = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", {30'd0, bus.busy, bus.done}, 32'd0);
    check("abort_product", {bus.product_hi, bus.product_lo}, 32'd0);
    repeat (20) @(negedge clk);
    runOp(16'd7, 16'd9, 32'h0000_003F, 1'b0);

    // Abort in the final iteration beats completion.
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'hFFFF; bus.mplier = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    check("last_iter_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_last_status", {30'd0, bus.busy, bus.done}, 32'd0);
    check("abort_last_product", {bus.product_hi, bus.product_lo}, 32'd0);
    repeat (3) @(negedge clk);

    // start and abort during DONE are ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'd3; bus.mplier = 16'd5;
    expQ.push_back(32'h0000_000F);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    check("done_at_17", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("done_ignores_start", {30'd0, bus.busy, bus.done}, 32'd0);
    check("done_ignores_abort", {bus.product_hi, bus.product_lo}, 32'h0000_000F);
    repeat (2) @(negedge clk);

    // Asynchronous reset in iteration 10 clears everything at once.
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'h1234; bus.mplier = 16'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_status", {30'd0, bus.busy, bus.done}, 32'd0);
    check("async_reset_product", {bus.product_hi, bus.product_lo}, 32'd0);
    check("async_reset_alu", {bus.alu_InA, bus.alu_InB}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    runOp(16'h1234, 16'h5678, 32'h0626_0060, 1'b1);

    // start held high: one result every 18 cycles; operand wiggles during RUN are ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'd2; bus.mplier = 16'd2;
    repeat (3) expQ.push_back(32'h0000_0004);
    for (int k = 1; k <= 100 && doneAt.size() < 3; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneAt.push_back(k);
      bus.mcand = (bus.busy === 1'b1) ? 16'd9 : 16'd2;
      if (doneAt.size() == 3) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    bus.mcand = 16'd2;
    check("b2b_done_count", 32'(doneAt.size()), 32'd3);
    if (doneAt.size() == 3) begin
      check("b2b_first", 32'(doneAt[0]), 32'd17);
      check("b2b_period1", 32'(doneAt[1] - doneAt[0]), 32'd18);
      check("b2b_period2", 32'(doneAt[2] - doneAt[1]), 32'd18);
    end
    repeat (25) @(negedge clk);
    check("idle_after_b2b", {30'd0, bus.busy, bus.done}, 32'd0);
    check("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
